// File: rtl/moore_pattern_serializer_pkg.sv
// Shared encodings for the pattern serializer and the detector benches.
// State values and idle line level live here so both sides agree.
package moore_pattern_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_e;

endpackage

// File: rtl/moore_pattern_serializer_if.sv
// Word handshake into the serializer.
// The source holds Valid until it sees Ready.
interface moore_pattern_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] Data;
  logic             Valid;
  logic             Ready;

  modport master (
    output Data,
    output Valid,
    input  Ready
  );

  modport slave (
    input  Data,
    input  Valid,
    output Ready
  );

endinterface

// File: rtl/moore_pattern_serializer_piso_shift_reg.sv
// Parallel-in / serial-out register, MSB first.
// Idle level fills from the LSB so the line drains to idle.
module piso_shift_reg
  import moore_pattern_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], IDLE_LEVEL};
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[WIDTH-1];

endmodule

// File: rtl/moore_pattern_serializer.sv
// Serializes WIDTH-bit words MSB first with an idle gap.
// Every output comes straight from a flop.
module moore_pattern_serializer
  import moore_pattern_serializer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic Clk,
  input  logic Rst,
  moore_pattern_serializer_if.slave s,
  output logic Output,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          load;
  logic          shift;

  assign accept = s.Valid & ready_q;

  // Next state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CNT_LAST;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          gcnt_d  = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == SHIFT) && (cnt_q == '0);
  end

  // State, counters and output flops.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk_i  (Clk),
    .clr_ni (Rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (s.Data),
    .ser_o  (Output)
  );

  assign s.Ready = ready_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_moore_pattern_serializer.sv
// Bench for the pattern serializer: vectors, corner sequences,
// loopback detector and random traffic against a frame model.
module tb_moore_pattern_serializer;
  import moore_pattern_serializer_pkg::*;

  typedef struct packed {
    logic o;
    logic r;
    logic b;
    logic d;
  } rec_t;

  typedef struct {
    logic [3:0] data;
    logic [5:0] out;
    logic [5:0] done;
    logic [5:0] rdy;
  } vec_t;

  localparam rec_t IDLE_REC = rec_t'(4'b0100);

  logic Clk;
  logic Rst;
  logic o4, bz4, dn4;
  logic o8, bz8, dn8;

  int checks;
  int errors;

  rec_t q4[$];
  rec_t q8[$];
  rec_t cur4;
  rec_t cur8;

  vec_t tbl[4];

  moore_pattern_serializer_if #(.WIDTH(4)) b4 ();
  moore_pattern_serializer_if #(.WIDTH(8)) b8 ();

  moore_pattern_serializer #(
    .WIDTH(4),
    .GAP_CYCLES(1)
  ) dut4 (
    .Clk   (Clk),
    .Rst   (Rst),
    .s     (b4.slave),
    .Output(o4),
    .Busy  (bz4),
    .Done  (dn4)
  );

  moore_pattern_serializer #(
    .WIDTH(8),
    .GAP_CYCLES(0)
  ) dut8 (
    .Clk   (Clk),
    .Rst   (Rst),
    .s     (b8.slave),
    .Output(o8),
    .Busy  (bz8),
    .Done  (dn8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock edge: advance the frame model, then compare.
  task automatic step();
    @(posedge Clk);
    if (!Rst) begin
      q4.delete();
      q8.delete();
      cur4 = IDLE_REC;
      cur8 = IDLE_REC;
    end else begin
      if (cur4.r && b4.Valid) begin
        for (int i = 3; i >= 0; i--)
          q4.push_back(rec_t'({b4.Data[i], 3'b010}));
        q4.push_back(rec_t'(4'b0011));
      end
      if (q4.size() > 0) cur4 = q4.pop_front();
      else cur4 = IDLE_REC;
      if (cur8.r && b8.Valid) begin
        for (int i = 7; i >= 0; i--)
          q8.push_back(rec_t'({b8.Data[i], 3'b010}));
        q8.push_back(rec_t'(4'b0101));
      end
      if (q8.size() > 0) cur8 = q8.pop_front();
      else cur8 = IDLE_REC;
    end
    #1;
    chk("model4", {o4, b4.Ready, bz4, dn4}, cur4);
    chk("model8", {o8, b8.Ready, bz8, dn8}, cur8);
  endtask

  initial begin
    logic [9:0] outv;
    logic [9:0] rdyv;
    logic [7:0] outv8;
    logic [3:0] hist;
    int d1, d2, ndone, hits;

    checks = 0;
    errors = 0;
    cur4 = IDLE_REC;
    cur8 = IDLE_REC;
    Rst = 1'b0;
    b4.Valid = 1'b0;
    b4.Data = '0;
    b8.Valid = 1'b0;
    b8.Data = '0;

    tbl[0] = '{4'b1011, 6'b101100, 6'b000010, 6'b000001};
    tbl[1] = '{4'b0110, 6'b011000, 6'b000010, 6'b000001};
    tbl[2] = '{4'b1000, 6'b100000, 6'b000010, 6'b000001};
    tbl[3] = '{4'b0001, 6'b000100, 6'b000010, 6'b000001};

    // reset held for two edges, Valid ignored meanwhile
    b4.Valid = 1'b1;
    step();
    step();
    chk("rst_out", o4, IDLE_LEVEL);
    chk("rst_ready", b4.Ready, 1);
    chk("rst_busy", bz4, 0);
    chk("rst_done", dn4, 0);
    b4.Valid = 1'b0;
    Rst = 1'b1;
    step();

    // table-driven single frames
    for (int n = 0; n < 4; n++) begin
      b4.Data = tbl[n].data;
      b4.Valid = 1'b1;
      step();
      b4.Valid = 1'b0;
      b4.Data = ~tbl[n].data;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) step();
        chk("tbl_out", o4, tbl[n].out[5-k]);
        chk("tbl_done", dn4, tbl[n].done[5-k]);
        chk("tbl_ready", b4.Ready, tbl[n].rdy[5-k]);
      end
    end

    // back-to-back with Valid held
    b4.Data = 4'b1011;
    b4.Valid = 1'b1;
    step();
    b4.Data = 4'b0110;
    outv = '0;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      if (k < 10) outv = {outv[8:0], o4};
      if (dn4) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 6) b4.Valid = 1'b0;
    end
    chk("b2b_out", outv, 10'b1011000110);
    chk("b2b_done1", d1, 4);
    chk("b2b_done_gap", d2 - d1, 6);

    // request during SHIFT is dropped
    b4.Data = 4'b1000;
    b4.Valid = 1'b1;
    step();
    b4.Valid = 1'b0;
    outv = '0;
    rdyv = '0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      outv = {outv[8:0], o4};
      rdyv = {rdyv[8:0], b4.Ready};
      ndone += int'(dn4);
      if (k == 1) begin
        b4.Valid = 1'b1;
        b4.Data = 4'b1111;
      end
      if (k == 2) b4.Valid = 1'b0;
    end
    chk("ign_out", outv, 10'b1000000000);
    chk("ign_ready", rdyv, 10'b0000011111);
    chk("ign_done", ndone, 1);

    // reset after the second bit
    b4.Data = 4'b1101;
    b4.Valid = 1'b1;
    step();
    b4.Valid = 1'b0;
    step();
    chk("mrst_bit2", o4, 1);
    Rst = 1'b0;
    step();
    chk("mrst_out", o4, 0);
    chk("mrst_ready", b4.Ready, 1);
    chk("mrst_busy", bz4, 0);
    chk("mrst_done", dn4, 0);
    Rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      ndone += int'(dn4) + int'(o4);
    end
    chk("mrst_quiet", ndone, 0);

    // WIDTH=8, no gap, Valid held for two frames
    b8.Data = 8'hA5;
    b8.Valid = 1'b1;
    step();
    outv8 = '0;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 19; k++) begin
      if (k > 0) step();
      if (k < 8) outv8 = {outv8[6:0], o8};
      if (k == 8) begin
        chk("w8_done", dn8, 1);
        chk("w8_ready", b8.Ready, 1);
      end
      if (k == 9) begin
        chk("w8_f2_bit", o8, 1);
        b8.Valid = 1'b0;
      end
      if (dn8) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    chk("w8_out", outv8, 8'hA5);
    chk("w8_done1", d1, 8);
    chk("w8_period", d2 - d1, 9);

    // loopback into a 1011 Moore detector
    hist = '0;
    for (int f = 0; f < 6; f++) begin
      b4.Data = (f % 2 == 1) ? 4'b0010 : 4'b1011;
      b4.Valid = 1'b1;
      step();
      b4.Valid = 1'b0;
      hits = 0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) step();
        hist = {hist[2:0], o4};
        if (hist == 4'b1011) hits++;
      end
      chk("loop_hits", hits, (f % 2 == 1) ? 0 : 1);
    end

    // random traffic against the frame model
    for (int c = 0; c < 800; c++) begin
      b4.Valid = 1'($urandom_range(0, 1));
      b4.Data = 4'($urandom);
      b8.Valid = 1'($urandom_range(0, 1));
      b8.Data = 8'($urandom);
      Rst = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
